// File: rtl/rptr_empty_prog_if.sv
// Read-side pointer/flag bundle between the FIFO read logic and its user; the
// master drives requests and the synchronised write pointer, the slave returns status.
interface rptr_empty_prog_if #(
  parameter int ASIZE = 4
);
  logic [ASIZE:0]   w2r_ptr;
  logic             rd_inc;
  logic             ae_wr;
  logic [ASIZE:0]   ae_thresh;
  logic             rd_underflow_clr;
  logic             rd_mem_en;
  logic [ASIZE-1:0] rd_addr;
  logic [ASIZE:0]   rd_ptr;
  logic             rd_empty;
  logic             rd_almost_empty;
  logic [ASIZE:0]   rd_count;
  logic             rd_underflow;

  modport master (
    output w2r_ptr, rd_inc, ae_wr, ae_thresh, rd_underflow_clr,
    input  rd_mem_en, rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_count, rd_underflow
  );

  modport slave (
    input  w2r_ptr, rd_inc, ae_wr, ae_thresh, rd_underflow_clr,
    output rd_mem_en, rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_count, rd_underflow
  );
endinterface

// File: rtl/rptr_empty_prog.sv
// Gray-FIFO read pointer, empty/almost-empty/count flags and sticky underflow; all
// outputs registered (1-cycle) except rd_mem_en; reads while empty are dropped, never stalled.
module rptr_empty_prog #(
  parameter int ASIZE      = 4,
  parameter int AE_DEFAULT = 1
) (
  input logic               rd_clk,
  input logic               rd_rst,
  rptr_empty_prog_if.slave  bus
);
  localparam logic [ASIZE:0] AE_INIT = AE_DEFAULT[ASIZE:0];

  logic [ASIZE:0] rbin_q, rbin_d;
  logic [ASIZE:0] rd_ptr_q, rd_ptr_d;
  logic           rd_empty_q, rd_empty_d;
  logic           rd_almost_empty_q, rd_almost_empty_d;
  logic [ASIZE:0] rd_count_q, rd_count_d;
  logic           rd_underflow_q, rd_underflow_d;
  logic [ASIZE:0] ae_reg_q, ae_reg_d;

  logic           acc;
  logic [ASIZE:0] wbin;
  logic [ASIZE:0] rgnext;
  logic [ASIZE:0] cnt_next;

  always_comb begin
    acc  = bus.rd_inc & ~rd_empty_q;
    wbin = '0;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (int i = 0; i <= ASIZE; i++) begin
      wbin[i] = ^(bus.w2r_ptr >> i);
    end
    rbin_d   = rbin_q + {{ASIZE{1'b0}}, acc};
    rgnext   = (rbin_d >> 1) ^ rbin_d;
    cnt_next = wbin - rbin_d;

    rd_ptr_d          = rgnext;
    rd_empty_d        = (rgnext == bus.w2r_ptr);
    rd_count_d        = cnt_next;
    rd_almost_empty_d = (cnt_next <= ae_reg_q);
    ae_reg_d          = bus.ae_wr ? bus.ae_thresh : ae_reg_q;

    // Set has priority over clear so a coincident error is never lost.
    rd_underflow_d = rd_underflow_q;
    if (bus.rd_underflow_clr) begin
      rd_underflow_d = 1'b0;
    end
    if (bus.rd_inc & rd_empty_q) begin
      rd_underflow_d = 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rbin_q            <= '0;
      rd_ptr_q          <= '0;
      rd_empty_q        <= 1'b1;
      rd_almost_empty_q <= 1'b1;
      rd_count_q        <= '0;
      rd_underflow_q    <= 1'b0;
      ae_reg_q          <= AE_INIT;
    end else begin
      rbin_q            <= rbin_d;
      rd_ptr_q          <= rd_ptr_d;
      rd_empty_q        <= rd_empty_d;
      rd_almost_empty_q <= rd_almost_empty_d;
      rd_count_q        <= rd_count_d;
      rd_underflow_q    <= rd_underflow_d;
      ae_reg_q          <= ae_reg_d;
    end
  end

  assign bus.rd_mem_en       = acc;
  assign bus.rd_addr         = rbin_q[ASIZE-1:0];
  assign bus.rd_ptr          = rd_ptr_q;
  assign bus.rd_empty        = rd_empty_q;
  assign bus.rd_almost_empty = rd_almost_empty_q;
  assign bus.rd_count        = rd_count_q;
  assign bus.rd_underflow    = rd_underflow_q;
endmodule

// File: doc/rptr_empty_prog.md
# rptr_empty_prog

Read-side pointer and flag controller for the team's Gray-pointer FIFOs, replacing the plain read-pointer/empty block. It lives in the read clock domain. It consumes the already-synchronised Gray write pointer and produces:
- the memory read address and Gray read pointer,
- a correctly reset empty flag,
- a binary occupancy count,
- a programmable almost-empty flag,
- a sticky underflow error.

The FIFO top instantiates it between the dual-port RAM and the read-to-write pointer synchroniser.

## Interface
Parameters:
- ASIZE, 4, address width; FIFO depth = 2^ASIZE; pointers are ASIZE+1 bits
- AE_DEFAULT, 1, value loaded into the almost-empty threshold register on reset

Ports:
- rd_clk  in  1  read-domain clock; all state updates on rising edge
- rd_rst  in  1  synchronous, active-high reset
- w2r_ptr  in  ASIZE+1  write pointer, Gray, already synchronised into rd_clk
- rd_inc  in  1  read request for the current head entry
- ae_wr  in  1  load ae_thresh into the threshold register
- ae_thresh  in  ASIZE+1  new almost-empty threshold
- rd_underflow_clr  in  1  clear sticky underflow
- rd_mem_en  out  1  combinational RAM read enable = rd_inc & !rd_empty
- rd_addr  out  ASIZE  RAM read address = rbin[ASIZE-1:0]
- rd_ptr  out  ASIZE+1  registered Gray read pointer, sent to the write domain
- rd_empty  out  1  registered empty flag
- rd_almost_empty  out  1  registered, high when occupancy <= threshold
- rd_count  out  ASIZE+1  registered occupancy, range 0..2^ASIZE
- rd_underflow  out  1  sticky, set by a read attempted while empty

## Operation
- State registers:
  - rbin: binary read pointer, ASIZE+1 bits
  - rd_ptr
  - rd_empty, rd_almost_empty
  - rd_count
  - rd_underflow
  - ae_reg: ASIZE+1 bits
- Accept: acc = rd_inc & !rd_empty. rbnext = rbin + acc, modulo 2^(ASIZE+1). rgnext = (rbnext >> 1) ^ rbnext.
- Write-pointer decode: wbin = Gray-to-binary of w2r_ptr (prefix XOR from MSB), combinational.
- Next occupancy: cnt_next = wbin - rbnext, modulo 2^(ASIZE+1). Legal range is 0..2^ASIZE because the upstream design guarantees it.
- Register updates each edge (not in reset):
  - rbin <= rbnext
  - rd_ptr <= rgnext
  - rd_empty <= (rgnext == w2r_ptr)
  - rd_count <= cnt_next
  - rd_almost_empty <= (cnt_next <= ae_reg)
- Underflow:
  - rd_underflow <= 1 when rd_inc & rd_empty.
  - Otherwise it is cleared by rd_underflow_clr.
  - If set and clear occur in the same cycle, set wins.
  - A read while empty never moves the pointers.
- Threshold: on ae_wr, ae_reg <= ae_thresh. The new value affects rd_almost_empty from the following edge's compare.
- Reset values:
  - rbin = 0, rd_ptr = 0
  - rd_empty = 1, rd_almost_empty = 1, rd_count = 0
  - rd_underflow = 0
  - ae_reg = AE_DEFAULT
- Boundary behaviour:
  - Wrap: rbin rolls from 2^(ASIZE+1)-1 to 0. rd_addr wraps every 2^ASIZE reads. Full/empty are distinguished by the pointer MSB.
  - Read of the last entry while a new write pointer arrives in the same cycle: rd_empty stays 0 and rd_count is unchanged.
  - Threshold of 0: rd_almost_empty equals rd_empty. Threshold >= 2^ASIZE: rd_almost_empty is always 1.
- Reset mid-operation: all registers return to their reset values on the next edge, and in-flight rd_inc is ignored. The write side must be reset together with this block.

## Timing
- All outputs except rd_mem_en are registered; rd_mem_en is combinational from rd_inc and rd_empty.
- Accepted read at edge N:
  - rd_addr, rd_ptr, rd_count and flags reflect it after edge N.
  - RAM data for the old rd_addr is sampled by the RAM at edge N when rd_mem_en = 1.
- Flag latency from w2r_ptr: the value present before edge N is reflected after edge N, a 1-cycle latency in this block. Synchroniser latency is extra and upstream.
- Flag update is pessimistic only toward empty: rd_empty deasserts no earlier than 1 cycle after w2r_ptr changes, so no false non-empty is possible.

## Test plan
- Reset: hold rd_rst for 2 cycles with w2r_ptr = 0.
  - Required: rd_empty = 1, rd_almost_empty = 1, rd_count = 0, rd_ptr = 0, rd_addr = 0, rd_underflow = 0.
- Fill, ASIZE = 4, ae_thresh = 2 loaded: step w2r_ptr through Gray 1, 3, 2.
  - Required: rd_count goes 1, 2, 3 one cycle after each step.
  - rd_empty falls after the first step.
  - rd_almost_empty stays 1 until count 3, then drops to 0.
- Drain: from count 3, assert rd_inc for 3 cycles.
  - Required: rd_addr goes 0, 1, 2, 3; rd_mem_en = 1 each cycle.
  - Final rd_ptr = 0b00010, rd_count = 0, rd_empty = 1.
- Underflow: with the FIFO empty, assert rd_inc for 1 cycle.
  - Required: rd_underflow = 1 next cycle, rbin unchanged, rd_mem_en = 0.
  - rd_underflow_clr then returns it to 0.
  - Simultaneous rd_inc-while-empty and clr leaves it at 1.
- Wrap, ASIZE = 4:
  - Set w2r_ptr to Gray(16) = 0b11000. Required: rd_count = 16.
  - Read 16 entries. Required: rd_addr back to 0, rd_ptr = 0b11000, rd_empty = 1.
  - Repeat once more to cross binary 31 -> 0.
- Simultaneous and reset: at count 1, read while w2r_ptr advances by 1.
  - Required: rd_count stays 1, rd_empty stays 0.
  - Then assert rd_rst mid-burst. Required: all outputs reach reset values after one edge.
